// File: rtl/u_seqrdiv_pkg.sv
// Shared types and constants for the sequential restoring divider.
// State encoding, default width and counter sizing live here so the top and its step cell agree.
package u_seqrdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_N = 8;

    // The counter must hold the full 2N iteration count, hence 2N+1 distinct values.
    function automatic int cnt_width(input int n);
        return $clog2(2 * n + 1);
    endfunction

endpackage

// File: rtl/u_seqrdiv_step.sv
// Single restoring-division iteration: shift one dividend bit into the partial
// remainder, subtract the divisor when it fits, and emit the quotient bit.
module u_seqrdiv_step #(
    parameter int N = 8
) (
    input  logic [N:0]   r,
    input  logic         q_msb,
    input  logic [N-1:0] b,
    output logic [N:0]   r_next,
    output logic         qbit
);

    logic [N+1:0] r_wide;
    logic [N:0]   diff;

    assign r_wide = {r, q_msb};
    assign qbit   = (r_wide >= {2'b00, b});
    // When qbit is set the shifted value is below 2b, so N+1 bits hold the difference.
    assign diff   = r_wide[N:0] - {1'b0, b};
    assign r_next = qbit ? diff : r_wide[N:0];

endmodule

// File: rtl/u_seqrdiv16x8.sv
// Sequential unsigned radix-2 restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional macro U_SEQRDIV_SKIP_EN skips the N leading all-zero iterations when the dividend's upper half is zero.
module u_seqrdiv16x8
    import u_seqrdiv_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quot,
    output logic [N-1:0]   rem,
    output logic           div_zero
);

    localparam int CW = cnt_width(N);

    state_t         state, state_next;
    logic [2*N-1:0] q_reg;
    logic [N:0]     r_reg;
    logic [N-1:0]   b_reg;
    logic [CW-1:0]  cnt;
    logic           dz_reg;
    logic [N:0]     r_step;
    logic           qbit;

    u_seqrdiv_step #(.N(N)) u_step (
        .r      (r_reg),
        .q_msb  (q_reg[2*N-1]),
        .b      (b_reg),
        .r_next (r_step),
        .qbit   (qbit)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (b == '0) ? DONE : RUN;
            end
            RUN: begin
                if (cnt == CW'(1)) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg  <= '0;
            r_reg  <= '0;
            b_reg  <= '0;
            cnt    <= '0;
            dz_reg <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        b_reg <= b;
                        if (b == '0) begin
                            // Divide-by-zero returns a saturated quotient and the low dividend half.
                            q_reg  <= '1;
                            r_reg  <= {1'b0, a[N-1:0]};
                            cnt    <= '0;
                            dz_reg <= 1'b1;
                        end else begin
                            r_reg  <= '0;
                            dz_reg <= 1'b0;
`ifdef U_SEQRDIV_SKIP_EN
                            if (a[2*N-1:N] == '0) begin
                                q_reg <= {a[N-1:0], {N{1'b0}}};
                                cnt   <= CW'(N);
                            end else begin
                                q_reg <= a;
                                cnt   <= CW'(2 * N);
                            end
`else
                            q_reg <= a;
                            cnt   <= CW'(2 * N);
`endif
                        end
                    end
                end
                RUN: begin
                    q_reg <= {q_reg[2*N-2:0], qbit};
                    r_reg <= r_step;
                    cnt   <= cnt - CW'(1);
                end
                DONE: begin
                    if (out_ready) dz_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign quot     = q_reg;
    assign rem      = r_reg[N-1:0];
    assign div_zero = dz_reg;

endmodule

// File: tb/tb_u_seqrdiv16x8.sv
// Directed bench for u_seqrdiv16x8 at N=8: hand-computed quotients, remainders, latencies,
// back-pressure hold, divide-by-zero and mid-run reset.
module tb_u_seqrdiv16x8;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] quot;
    logic [N-1:0]   rem;
    logic           div_zero;

    int n_checks = 0;
    int n_pass   = 0;

    u_seqrdiv16x8 #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

`ifdef U_SEQRDIV_SKIP_EN
    localparam int LAT_SMALL = N;
`else
    localparam int LAT_SMALL = 2 * N;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Runs one operation; latency is counted in edges after the acceptance edge.
    // All driving and sampling happens on the falling edge.
    task automatic do_op(input string tag, input logic [15:0] av, input logic [7:0] bv,
                         input logic [15:0] eq, input logic [7:0] er, input logic edz,
                         input int elat, input bit hold);
        int lat;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 8'h5A;
        lat      = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_quot"}, 32'(quot), 32'(eq));
        check({tag, "_rem"}, 32'(rem), 32'(er));
        check({tag, "_dz"}, 32'(div_zero), 32'(edz));
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                in_valid = i[0];
                a        = 16'h0100 + 16'(i);
                b        = 8'(i + 2);
                @(negedge clk);
                check({tag, "_hold_ov"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_ir"}, 32'(in_ready), 32'd0);
                check({tag, "_hold_q"}, 32'(quot), 32'(eq));
                check({tag, "_hold_r"}, 32'(rem), 32'(er));
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_ov"}, 32'(out_valid), 32'd0);
        check({tag, "_post_ir"}, 32'(in_ready), 32'd1);
        check({tag, "_post_dz"}, 32'(div_zero), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ir", 32'(in_ready), 32'd1);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_q", 32'(quot), 32'd0);
        check("rst_r", 32'(rem), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);

        do_op("d1000_7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 2 * N, 1'b0);
        do_op("d200_3", 16'd200, 8'd3, 16'd66, 8'd2, 1'b0, LAT_SMALL, 1'b0);
        // Zero divisor is resolved on the acceptance edge itself.
        do_op("dz", 16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1, 0, 1'b0);
        do_op("dffff_1", 16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0, 2 * N, 1'b0);
        do_op("dfe01_ff", 16'hFE01, 8'hFF, 16'h00FF, 8'd0, 1'b0, 2 * N, 1'b0);
        do_op("hold", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 2 * N, 1'b1);
        // Accepted on the edge right after the previous handshake.
        do_op("b2b", 16'd255, 8'd16, 16'd15, 8'd15, 1'b0, LAT_SMALL, 1'b0);

        // Reset landing on the fifth iteration edge.
        a        = 16'd1000;
        b        = 8'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("run_ir", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_ir", 32'(in_ready), 32'd1);
        check("mrst_ov", 32'(out_valid), 32'd0);
        check("mrst_q", 32'(quot), 32'd0);
        check("mrst_r", 32'(rem), 32'd0);
        check("mrst_dz", 32'(div_zero), 32'd0);
        do_op("after_rst", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 2 * N, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
